// File: rtl/lot_gate_controller_if.sv
// Signal bundle between the lot gate controller and its surroundings:
// request buttons, occupancy, car pulses in; gate actuator and status out.
interface lot_gate_controller_if #(
   parameter int OW = 5
);
   logic          req_in;
   logic          req_out;
   logic [OW-1:0] occupancy;
   logic          car_entered;
   logic          car_exited;
   logic          gate_up;
   logic          grant_in;
   logic          grant_out;
   logic          deny_full;
   logic          done;
   logic          timeout;

   // Controller side
   modport slave (
      input  req_in, req_out, occupancy, car_entered, car_exited,
      output gate_up, grant_in, grant_out, deny_full, done, timeout
   );

   // Environment side (buttons, lot_counter, counter_25, actuator, LEDs)
   modport master (
      output req_in, req_out, occupancy, car_entered, car_exited,
      input  gate_up, grant_in, grant_out, deny_full, done, timeout
   );
endinterface

// File: rtl/lot_gate_controller.sv
// Shared entry/exit gate sequencer. Arbitrates in/out requests round-robin,
// refuses entry when the lot is full, and walks the gate through
// OPENING -> PASSING -> CLOSING, closing on a matching car pulse or a timeout.
module lot_gate_controller #(
   parameter int CAPACITY     = 25,
   parameter int MOVE_CYCLES  = 4,
   parameter int PASS_TIMEOUT = 16,
   parameter int OW           = 5
) (
   input  logic                  clk,
   input  logic                  rst,   // asynchronous, active-low
   lot_gate_controller_if.slave  bus
);

   // One timer serves every phase; it must reach the longer of the two limits.
   localparam int TMAX = (MOVE_CYCLES > PASS_TIMEOUT) ? MOVE_CYCLES : PASS_TIMEOUT;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_CYCLES - 1);
   localparam logic [TW-1:0] PASS_LAST = TW'(PASS_TIMEOUT - 1);
   localparam logic [TW-1:0] T_ZERO    = {TW{1'b0}};
   localparam logic [TW-1:0] T_ONE     = TW'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OPENING = 2'd1,
      PASSING = 2'd2,
      CLOSING = 2'd3
   } state_t;

   typedef enum logic {
      DIR_OUT = 1'b0,
      DIR_IN  = 1'b1
   } dir_t;

   state_t        state_q, state_d;
   dir_t          last_dir_q, last_dir_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          gate_up_q, gate_up_d;
   logic          grant_in_q, grant_in_d;
   logic          grant_out_q, grant_out_d;
   logic          deny_full_q, deny_full_d;
   logic          done_q, done_d;
   logic          timeout_q, timeout_d;

   logic [OW-1:0] occ_s;
   logic          room_s;
   logic          in_ok_s;
   logic          pick_in_s;
   logic          pick_out_s;
   logic          match_s;

   assign occ_s  = bus.occupancy;
   assign room_s = (32'(occ_s) < 32'(CAPACITY));

   // Request qualification and round-robin tie break (tie goes opposite last_dir)
   always_comb begin
      in_ok_s    = bus.req_in && room_s;
      pick_in_s  = in_ok_s && (!bus.req_out || (last_dir_q == DIR_OUT));
      pick_out_s = bus.req_out && (!in_ok_s || (last_dir_q == DIR_IN));
      match_s    = (bus.car_entered && grant_in_q) || (bus.car_exited && grant_out_q);
   end

   // Next-state, timer and next-output computation
   always_comb begin
      state_d     = state_q;
      last_dir_d  = last_dir_q;
      timer_d     = timer_q;
      grant_in_d  = grant_in_q;
      grant_out_d = grant_out_q;
      deny_full_d = 1'b0;
      done_d      = 1'b0;
      timeout_d   = 1'b0;
      gate_up_d   = 1'b0;

      case (state_q)
         IDLE: begin
            timer_d     = T_ZERO;
            grant_in_d  = 1'b0;
            grant_out_d = 1'b0;
            if (pick_in_s) begin
               state_d    = OPENING;
               grant_in_d = 1'b1;
               last_dir_d = DIR_IN;
            end else if (pick_out_s) begin
               state_d     = OPENING;
               grant_out_d = 1'b1;
               last_dir_d  = DIR_OUT;
            end else begin
               deny_full_d = bus.req_in && !room_s;
            end
         end
         OPENING: begin
            if (timer_q == MOVE_LAST) begin
               state_d = PASSING;
               timer_d = T_ZERO;
            end else begin
               timer_d = timer_q + T_ONE;
            end
         end
         PASSING: begin
            // A matching car on the expiry cycle wins over the timeout.
            if (match_s) begin
               state_d = CLOSING;
               timer_d = T_ZERO;
            end else if (timer_q == PASS_LAST) begin
               state_d   = CLOSING;
               timer_d   = T_ZERO;
               timeout_d = 1'b1;
            end else begin
               timer_d = timer_q + T_ONE;
            end
         end
         CLOSING: begin
            if (timer_q == MOVE_LAST) begin
               state_d     = IDLE;
               timer_d     = T_ZERO;
               grant_in_d  = 1'b0;
               grant_out_d = 1'b0;
               done_d      = 1'b1;
            end else begin
               timer_d = timer_q + T_ONE;
            end
         end
         default: begin
            state_d     = IDLE;
            timer_d     = T_ZERO;
            grant_in_d  = 1'b0;
            grant_out_d = 1'b0;
         end
      endcase

      gate_up_d = (state_d == OPENING) || (state_d == PASSING);
   end

   // State, timer and registered outputs; reset also aborts any transaction
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         last_dir_q  <= DIR_OUT;
         timer_q     <= T_ZERO;
         gate_up_q   <= 1'b0;
         grant_in_q  <= 1'b0;
         grant_out_q <= 1'b0;
         deny_full_q <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_dir_q  <= last_dir_d;
         timer_q     <= timer_d;
         gate_up_q   <= gate_up_d;
         grant_in_q  <= grant_in_d;
         grant_out_q <= grant_out_d;
         deny_full_q <= deny_full_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
      end
   end

   assign bus.gate_up   = gate_up_q;
   assign bus.grant_in  = grant_in_q;
   assign bus.grant_out = grant_out_q;
   assign bus.deny_full = deny_full_q;
   assign bus.done      = done_q;
   assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_lot_gate_controller.sv
// Directed bench for lot_gate_controller (MOVE_CYCLES=4, PASS_TIMEOUT=16).
// Cycle n is the interval after edge n; inputs set in cycle n are sampled
// at edge n+1 and their effect is visible in cycle n+1.
module tb_lot_gate_controller;

   logic clk;
   logic rst;
   int   chk_cnt;
   int   err_cnt;

   lot_gate_controller_if #(.OW(5)) bus ();

   lot_gate_controller #(
      .CAPACITY    (25),
      .MOVE_CYCLES (4),
      .PASS_TIMEOUT(16),
      .OW          (5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Free-running 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_val(input string tag, input logic obs, input logic exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Called in the grant cycle (cycle 1); ends in the done cycle (cycle 10).
   task automatic finish_txn(input logic is_in);
      tick(4);                       // cycle 5: first PASSING cycle
      if (is_in) bus.car_entered = 1'b1;
      else       bus.car_exited  = 1'b1;
      tick(1);                       // cycle 6: CLOSING
      bus.car_entered = 1'b0;
      bus.car_exited  = 1'b0;
      check_val("txn_close_gate", bus.gate_up, 1'b0);
      tick(3);                       // cycle 9: last CLOSING cycle
      check_val("txn_no_early_done", bus.done, 1'b0);
      tick(1);                       // cycle 10: IDLE, done pulse
      check_val("txn_done", bus.done, 1'b1);
      check_val("txn_grant_in_clr", bus.grant_in, 1'b0);
      check_val("txn_grant_out_clr", bus.grant_out, 1'b0);
   endtask

   initial begin
      chk_cnt         = 0;
      err_cnt         = 0;
      rst             = 1'b0;
      bus.req_in      = 1'b0;
      bus.req_out     = 1'b0;
      bus.occupancy   = 5'd0;
      bus.car_entered = 1'b0;
      bus.car_exited  = 1'b0;

      // 1. Reset and single entry
      tick(2);
      check_val("rst_gate_up", bus.gate_up, 1'b0);
      check_val("rst_grant_in", bus.grant_in, 1'b0);
      check_val("rst_grant_out", bus.grant_out, 1'b0);
      check_val("rst_deny", bus.deny_full, 1'b0);
      check_val("rst_done", bus.done, 1'b0);
      check_val("rst_timeout", bus.timeout, 1'b0);
      rst           = 1'b1;
      bus.occupancy = 5'd3;
      bus.req_in    = 1'b1;          // cycle 0
      tick(1);                       // cycle 1
      check_val("s1_grant_in", bus.grant_in, 1'b1);
      check_val("s1_gate_up", bus.gate_up, 1'b1);
      check_val("s1_grant_out", bus.grant_out, 1'b0);
      check_val("s1_deny", bus.deny_full, 1'b0);
      bus.req_in = 1'b0;
      tick(7);                       // cycle 8
      check_val("s1_gate_held", bus.gate_up, 1'b1);
      bus.car_entered = 1'b1;
      tick(1);                       // cycle 9
      bus.car_entered = 1'b0;
      check_val("s1_closing", bus.gate_up, 1'b0);
      check_val("s1_grant_held", bus.grant_in, 1'b1);
      tick(3);                       // cycle 12
      check_val("s1_done_early", bus.done, 1'b0);
      tick(1);                       // cycle 13
      check_val("s1_done", bus.done, 1'b1);
      check_val("s1_grant_clr", bus.grant_in, 1'b0);
      tick(1);
      check_val("s1_done_pulse", bus.done, 1'b0);

      // 2. Full lot: deny entry, then exit request is granted
      bus.occupancy = 5'd25;
      bus.req_in    = 1'b1;
      tick(1);
      check_val("s2_deny", bus.deny_full, 1'b1);
      check_val("s2_no_grant", bus.grant_in, 1'b0);
      check_val("s2_gate_down", bus.gate_up, 1'b0);
      tick(1);
      check_val("s2_deny_hold", bus.deny_full, 1'b1);
      check_val("s2_no_grant2", bus.grant_in, 1'b0);
      bus.req_out = 1'b1;
      tick(1);
      check_val("s2_grant_out", bus.grant_out, 1'b1);
      check_val("s2_deny_clr", bus.deny_full, 1'b0);
      check_val("s2_gate_up", bus.gate_up, 1'b1);
      check_val("s2_grant_in", bus.grant_in, 1'b0);
      bus.req_in  = 1'b0;
      bus.req_out = 1'b0;
      finish_txn(1'b0);

      // 3. Simultaneous held requests alternate, starting with entry
      rst = 1'b0;
      tick(1);
      rst           = 1'b1;
      bus.occupancy = 5'd3;
      bus.req_in    = 1'b1;
      bus.req_out   = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick(1);
         check_val("s3_grant_in", bus.grant_in, (k % 2) == 0);
         check_val("s3_grant_out", bus.grant_out, (k % 2) == 1);
         finish_txn((k % 2) == 0);
      end
      bus.req_in  = 1'b0;
      bus.req_out = 1'b0;

      // 4. Timeout on exit; stray car_entered ignored
      tick(1);
      bus.req_out = 1'b1;            // cycle 0
      tick(1);                       // cycle 1
      check_val("s4_grant_out", bus.grant_out, 1'b1);
      bus.req_out = 1'b0;
      tick(6);                       // cycle 7
      bus.car_entered = 1'b1;
      tick(1);                       // cycle 8
      bus.car_entered = 1'b0;
      check_val("s4_ignore_enter", bus.gate_up, 1'b1);
      tick(12);                      // cycle 20: last PASSING cycle
      check_val("s4_gate_last", bus.gate_up, 1'b1);
      check_val("s4_no_to_yet", bus.timeout, 1'b0);
      tick(1);                       // cycle 21
      check_val("s4_timeout", bus.timeout, 1'b1);
      check_val("s4_closing", bus.gate_up, 1'b0);
      check_val("s4_grant_held", bus.grant_out, 1'b1);
      tick(1);
      check_val("s4_to_pulse", bus.timeout, 1'b0);
      tick(2);                       // cycle 24
      check_val("s4_done_early", bus.done, 1'b0);
      tick(1);                       // cycle 25
      check_val("s4_done", bus.done, 1'b1);

      // 5. Matching car on the expiry cycle suppresses the timeout
      bus.req_out = 1'b1;
      tick(1);
      check_val("s5_grant_out", bus.grant_out, 1'b1);
      bus.req_out = 1'b0;
      tick(19);                      // cycle 20
      bus.car_exited = 1'b1;
      tick(1);                       // cycle 21
      bus.car_exited = 1'b0;
      check_val("s5_no_timeout", bus.timeout, 1'b0);
      check_val("s5_closing", bus.gate_up, 1'b0);
      tick(4);                       // cycle 25
      check_val("s5_done", bus.done, 1'b1);

      // 6. Asynchronous reset mid-PASSING, then boundary occupancy entry
      bus.req_in = 1'b1;
      tick(1);
      check_val("s6_grant_in", bus.grant_in, 1'b1);
      bus.req_in = 1'b0;
      tick(5);                       // cycle 6: PASSING
      #3;
      rst = 1'b0;
      #1;
      check_val("s6_rst_gate", bus.gate_up, 1'b0);
      check_val("s6_rst_grant_in", bus.grant_in, 1'b0);
      check_val("s6_rst_grant_out", bus.grant_out, 1'b0);
      tick(1);
      check_val("s6_rst_hold", bus.gate_up, 1'b0);
      rst           = 1'b1;
      bus.occupancy = 5'd24;         // one below capacity still admits
      bus.req_in    = 1'b1;
      tick(1);
      check_val("s6_regrant", bus.grant_in, 1'b1);
      check_val("s6_regate", bus.gate_up, 1'b1);
      check_val("s6_no_deny", bus.deny_full, 1'b0);
      bus.req_in = 1'b0;
      finish_txn(1'b1);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/lot_gate_controller.md
Name: lot_gate_controller

Overview:
- Sequences a single shared entry/exit gate lane for the parking lot.
- Arbitrates between the inbound and outbound request buttons and refuses entry when occupancy reaches capacity.
- Drives the gate through open/pass/close phases, closing on the lot_counter enter/exit pulses or on a timeout.
- Sits beside lot_counter and counter_25 in the top level: it consumes their enter/exit pulses and occupancy count, and drives the gate actuator and status LEDs.

Parameters:
- CAPACITY, 25, occupancy at or above which entry is denied.
- MOVE_CYCLES, 4, cycles the gate spends opening and cycles it spends closing (>=1).
- PASS_TIMEOUT, 16, maximum cycles in PASSING without a matching car event (>=1).
- OW, 5, occupancy width.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- req_in  input  1  level; driver wants to enter.
- req_out  input  1  level; driver wants to exit.
- occupancy  input  OW  current car count from counter_25.
- car_entered  input  1  one-cycle pulse from lot_counter, enter.
- car_exited  input  1  one-cycle pulse from lot_counter, exit.
- gate_up  output  1  gate actuator command; 1 = raise or hold raised.
- grant_in  output  1  entry transaction in progress.
- grant_out  output  1  exit transaction in progress.
- deny_full  output  1  entry refused because the lot is full.
- done  output  1  one-cycle pulse when a transaction completes.
- timeout  output  1  one-cycle pulse when PASSING expires.

Behaviour:
- All outputs are registered.
- rst low: state=IDLE; gate_up, grant_in, grant_out, deny_full, done, timeout = 0; timer = 0; last_dir = OUT, so the first tie goes to entry. Applies immediately, including mid-transaction.
- FSM states: IDLE, OPENING, PASSING, CLOSING.
- IDLE, sampled every cycle:
  - in_ok = req_in && (occupancy < CAPACITY).
  - in_ok && !req_out -> OPENING, grant_in=1.
  - req_out && !in_ok -> OPENING, grant_out=1.
  - in_ok && req_out -> grant the direction opposite last_dir (round-robin); last_dir updates on each grant.
  - Neither condition true -> stay in IDLE.
  - deny_full = req_in && occupancy >= CAPACITY, evaluated in IDLE only; forced to 0 in other states.
- Grant latency: request asserted at edge t -> grant and gate_up = 1 after edge t+1.
- OPENING:
  - gate_up=1; stays MOVE_CYCLES cycles (timer counts 0..MOVE_CYCLES-1), then PASSING with timer cleared.
- PASSING:
  - gate_up=1.
  - Matching event (car_entered with grant_in, or car_exited with grant_out) -> CLOSING next cycle.
  - Non-matching event is ignored.
  - Timer reaches PASS_TIMEOUT-1 with no matching event -> CLOSING and timeout=1 for that one cycle.
  - A matching event on the same cycle as expiry counts as the event: no timeout pulse.
- CLOSING:
  - gate_up=0; stays MOVE_CYCLES cycles.
  - Then IDLE; grant_in/grant_out cleared; done=1 for the first IDLE cycle.
  - That first IDLE cycle also evaluates requests, so a back-to-back grant is possible on the next edge.
- Grants are held for the entire transaction. req_in/req_out changes outside IDLE are ignored.
- Occupancy changes outside IDLE do not abort an active entry.
- Timer width is sized for max(MOVE_CYCLES, PASS_TIMEOUT); no wrap is possible within a state.

Test Plan (MOVE_CYCLES=4, PASS_TIMEOUT=16):
1. Reset and single entry: rst low for 2 cycles, then high; occupancy=3, req_in=1 at cycle 0 -> grant_in=1 and gate_up=1 from cycle 1; PASSING from cycle 5; car_entered at cycle 8 -> gate_up=0 at cycle 9; done=1 at cycle 13.
2. Full lot: occupancy=25, req_in=1 -> deny_full=1 from the next cycle, grant_in never asserts, gate_up stays 0. Add req_out=1 -> grant_out=1 and deny_full=0 on the next edge.
3. Simultaneous requests: req_in=req_out=1 held after reset -> first grant_in, then after done grant_out, then grant_in; strict alternation across 4 transactions.
4. Timeout: grant_out, no car_exited for 16 PASSING cycles -> timeout=1 for exactly one cycle, CLOSING for 4 cycles, done pulse; a car_entered during PASSING has no effect.
5. Expiry collision: car_exited on the last PASSING cycle -> CLOSING with timeout=0.
6. Reset mid-PASSING: rst low asynchronously between edges -> gate_up, grant_in, grant_out = 0 immediately; after release, req_in=1 with tie absent -> normal grant with 1-cycle latency.
